mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared sequential multiplier.
// Each grant latches operands, issues one start pulse and waits for done or a timeout.
module mul_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           ack0,
  output logic           ack1,
  output logic [2*W-1:0] result,
  output logic           err,
  output logic           busy,
  output logic           owner,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_result
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             err_q, err_d;
  logic             grant;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the requester not served most recently wins.
          grant   = (req0 && req1) ? ~last_q : req1;
          owner_d = grant;
          opa_d   = grant ? a1 : a0;
          opb_d   = grant ? b1 : b0;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Counter reads 0 during ISSUE and counts the cycles since mul_start.
        cnt_d   = cnt_q + 8'd1;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (mul_done) begin
          res_d   = mul_result;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    mul_start = (state_q == StIssue);
    ack0      = (state_q == StResp) && !owner_q;
    ack1      = (state_q == StResp) && owner_q;
    result    = (state_q == StResp) ? res_q : '0;
    err       = (state_q == StResp) && err_q;
    owner     = owner_q;
    mul_a     = opa_q;
    mul_b     = opb_q;
  end

endmodule
